// File: rtl/dense_layer_pkg.sv
// dense_layer_pkg: fixed-point types, tree depth and latency helpers.
// Shared by dense_layer and adder_tree; honours THREE_CYCLE_MULT_EN.
package dense_layer_pkg;

  localparam int DEF_WIDTH = 17;
  localparam int DEF_NFRAC = 10;

`ifdef THREE_CYCLE_MULT_EN
  localparam int MULT_EXTRA = 2;
`else
  localparam int MULT_EXTRA = 0;
`endif

  typedef logic signed [DEF_WIDTH-1:0] word_t;
  typedef logic signed [2*DEF_WIDTH-1:0] prod_t;

  function automatic int tree_depth(input int n);
    int d;
    d = 0;
    while ((1 << d) < n) d = d + 1;
    return d;
  endfunction

  // element count entering tree level l
  function automatic int level_size(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  function automatic int lat(input int n);
    return 2 + MULT_EXTRA + tree_depth(n);
  endfunction

endpackage

// File: rtl/dense_layer_adder_tree.sv
// adder_tree: registered binary sum per column, depth ceil(log2(INPUT_SIZE)).
// Ports: clk, reset (sync, active-low), a[INPUT_SIZE][OUTPUT_SIZE], y[OUTPUT_SIZE].
module adder_tree
  import dense_layer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] a [INPUT_SIZE][OUTPUT_SIZE],
  output logic signed [WIDTH-1:0] y [OUTPUT_SIZE]
);

  localparam int L = tree_depth(INPUT_SIZE);

  if (L == 0) begin : g_pass
    assign y = a[0];
  end else begin : g_tree
    logic signed [WIDTH-1:0] lin [L][INPUT_SIZE][OUTPUT_SIZE];
    logic signed [WIDTH-1:0] st  [L][INPUT_SIZE][OUTPUT_SIZE];

    for (genvar l = 0; l < L; l++) begin : g_lvl
      localparam int N = level_size(INPUT_SIZE, l);

      if (l == 0) begin : g_src0
        assign lin[0] = a;
      end else begin : g_srcn
        assign lin[l] = st[l-1];
      end

      for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_node
        for (genvar c = 0; c < OUTPUT_SIZE; c++) begin : g_col
          if (2*i+1 < N) begin : g_add
            always_ff @(posedge clk) begin
              if (!reset) st[l][i][c] <= '0;
              else st[l][i][c] <= lin[l][2*i][c] + lin[l][2*i+1][c];
            end
          end else if (2*i < N) begin : g_odd
            always_ff @(posedge clk) begin
              if (!reset) st[l][i][c] <= '0;
              else st[l][i][c] <= lin[l][2*i][c];
            end
          end else begin : g_nil
            always_ff @(posedge clk) begin
              st[l][i][c] <= '0;
            end
          end
        end
      end
    end

    for (genvar c = 0; c < OUTPUT_SIZE; c++) begin : g_out
      assign y[c] = st[L-1][0][c];
    end
  end

endmodule

// File: rtl/dense_layer.sv
// dense_layer: pipelined fixed-point y[c] = bias[c] + sum_r x[r]*w[r][c].
// Ports: clk, reset (sync, active-low), input_data, weights, bias, output_data. Macro: THREE_CYCLE_MULT_EN.
module dense_layer
  import dense_layer_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NFRAC       = DEF_NFRAC,
  parameter int INPUT_SIZE  = 32,
  parameter int OUTPUT_SIZE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] input_data  [INPUT_SIZE],
  input  logic signed [WIDTH-1:0] weights     [INPUT_SIZE*OUTPUT_SIZE],
  input  logic signed [WIDTH-1:0] bias        [OUTPUT_SIZE],
  output logic signed [WIDTH-1:0] output_data [OUTPUT_SIZE]
);

  logic signed [2*WIDTH-1:0] prod_q [INPUT_SIZE][OUTPUT_SIZE];
  logic signed [WIDTH-1:0]   resc   [INPUT_SIZE][OUTPUT_SIZE];
  logic signed [WIDTH-1:0]   tin    [INPUT_SIZE][OUTPUT_SIZE];
  logic signed [WIDTH-1:0]   tsum   [OUTPUT_SIZE];

  always_ff @(posedge clk) begin
    for (int r = 0; r < INPUT_SIZE; r++) begin
      for (int c = 0; c < OUTPUT_SIZE; c++) begin
        if (!reset) prod_q[r][c] <= '0;
        else prod_q[r][c] <=
          (2*WIDTH)'(input_data[r]) *
          (2*WIDTH)'(weights[r*OUTPUT_SIZE+c]);
      end
    end
  end

  // floor toward -inf on the low bits, wrap on the high bits
  always_comb begin
    for (int r = 0; r < INPUT_SIZE; r++) begin
      for (int c = 0; c < OUTPUT_SIZE; c++) begin
        resc[r][c] = WIDTH'(prod_q[r][c] >>> NFRAC);
      end
    end
  end

`ifdef THREE_CYCLE_MULT_EN
  logic signed [WIDTH-1:0] p1 [INPUT_SIZE][OUTPUT_SIZE];
  logic signed [WIDTH-1:0] p2 [INPUT_SIZE][OUTPUT_SIZE];

  always_ff @(posedge clk) begin
    for (int r = 0; r < INPUT_SIZE; r++) begin
      for (int c = 0; c < OUTPUT_SIZE; c++) begin
        if (!reset) begin
          p1[r][c] <= '0;
          p2[r][c] <= '0;
        end else begin
          p1[r][c] <= resc[r][c];
          p2[r][c] <= p1[r][c];
        end
      end
    end
  end

  always_comb tin = p2;
`else
  always_comb tin = resc;
`endif

  adder_tree #(
    .WIDTH       (WIDTH),
    .INPUT_SIZE  (INPUT_SIZE),
    .OUTPUT_SIZE (OUTPUT_SIZE)
  ) u_tree (
    .clk   (clk),
    .reset (reset),
    .a     (tin),
    .y     (tsum)
  );

  always_ff @(posedge clk) begin
    for (int c = 0; c < OUTPUT_SIZE; c++) begin
      if (!reset) output_data[c] <= '0;
      else output_data[c] <= tsum[c] + bias[c];
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// tb_dense_layer: directed table-driven checks of dense_layer.
// Three instances: 7x5 integer, 1x1 Q4.4, 2x1 overflow.
module tb_dense_layer;

`ifdef THREE_CYCLE_MULT_EN
  localparam int E = 2;
`else
  localparam int E = 0;
`endif
  localparam int LAT_A = 5 + E;
  localparam int LAT_B = 2 + E;
  localparam int LAT_C = 3 + E;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic signed [7:0] a_in [7];
  logic signed [7:0] a_w [35];
  logic signed [7:0] a_b [5];
  logic signed [7:0] a_out [5];

  logic signed [7:0] b_in [1];
  logic signed [7:0] b_w [1];
  logic signed [7:0] b_b [1];
  logic signed [7:0] b_out [1];

  logic signed [7:0] c_in [2];
  logic signed [7:0] c_w [2];
  logic signed [7:0] c_b [1];
  logic signed [7:0] c_out [1];

  dense_layer #(.WIDTH(8), .NFRAC(0), .INPUT_SIZE(7), .OUTPUT_SIZE(5)) dut_a (
    .clk(clk), .reset(reset), .input_data(a_in), .weights(a_w),
    .bias(a_b), .output_data(a_out));

  dense_layer #(.WIDTH(8), .NFRAC(4), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) dut_b (
    .clk(clk), .reset(reset), .input_data(b_in), .weights(b_w),
    .bias(b_b), .output_data(b_out));

  dense_layer #(.WIDTH(8), .NFRAC(0), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) dut_c (
    .clk(clk), .reset(reset), .input_data(c_in), .weights(c_w),
    .bias(c_b), .output_data(c_out));

  typedef struct {
    logic signed [7:0] in  [7];
    logic signed [7:0] exp [5];
  } vec_a_t;

  typedef struct {
    logic signed [7:0] in;
    logic signed [7:0] w;
    logic signed [7:0] exp;
  } vec_b_t;

  typedef struct {
    logic signed [7:0] in [2];
    logic signed [7:0] exp;
  } vec_c_t;

  localparam int NA = 6;
  localparam int NB = 4;
  localparam int NC = 4;

  vec_a_t ta [NA];
  vec_b_t tb [NB];
  vec_c_t tc [NC];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic signed [7:0] got,
                     input logic signed [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, got, exp);
    end
  endtask

  initial begin
    int j;
    ta[0].in = '{-1, 2, -3, 4, -5, 6, -7};
    ta[0].exp = '{-42, 4, 0, -44, -48};
    ta[1].in = '{1, 1, 1, 1, 1, 1, 1};
    ta[1].exp = '{29, 26, 33, 30, 37};
    ta[2].in = '{1, 0, 0, 0, 0, 0, 0};
    ta[2].exp = '{1, 2, 3, 4, 5};
    ta[3].in = '{0, 0, 0, 0, 1, 0, 0};
    ta[3].exp = '{9, 0, 1, 2, 3};
    ta[4].in = '{-1, -1, -1, -1, -1, -1, -1};
    ta[4].exp = '{-29, -26, -33, -30, -37};
    ta[5].in = '{10, 10, 10, 10, 10, 10, 10};
    ta[5].exp = '{34, 4, 74, 44, 114};

    tb[0] = '{in: 8'sh18, w: 8'sh18, exp: 8'sh24};
    tb[1] = '{in: 8'shE8, w: 8'sh18, exp: 8'shDC};
    tb[2] = '{in: 8'shFF, w: 8'sh01, exp: 8'shFF};
    tb[3] = '{in: 8'sh01, w: 8'sh01, exp: 8'sh00};

    tc[0].in = '{127, 1};    tc[0].exp = -128;
    tc[1].in = '{-128, -1};  tc[1].exp = 127;
    tc[2].in = '{100, 100};  tc[2].exp = -56;
    tc[3].in = '{3, -5};     tc[3].exp = -2;

    a_w = '{1, 2, 3, 4, 5,  3, 4, 5, 6, 7,  5, 6, 7, 8, 9,
            7, 8, 9, 0, 1,  9, 0, 1, 2, 3,  1, 2, 3, 4, 5,
            3, 4, 5, 6, 7};
    a_b = '{default: 0};
    a_in = '{default: 0};
    b_in = '{default: 0};
    b_w = '{default: 0};
    b_b = '{default: 0};
    c_in = '{default: 0};
    c_w = '{1, 1};
    c_b = '{default: 0};

    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) chk("reset_a", c, a_out[c], 8'sd0);
    chk("reset_b", 0, b_out[0], 8'sd0);
    chk("reset_c", 0, c_out[0], 8'sd0);
    reset = 1'b1;

    // back-to-back stream through the 7x5 layer
    for (int t = 0; t < NA + LAT_A - 1; t++) begin
      if (t < NA) a_in = ta[t].in;
      else a_in = '{default: 0};
      @(posedge clk);
      #1;
      j = t - (LAT_A - 1);
      if (j >= 0)
        for (int c = 0; c < 5; c++) chk("stream_a", j*5 + c, a_out[c], ta[j].exp[c]);
    end

    // fraction / truncation
    for (int t = 0; t < NB + LAT_B - 1; t++) begin
      if (t < NB) begin
        b_in[0] = tb[t].in;
        b_w[0] = tb[t].w;
      end else begin
        b_in[0] = 8'sd0;
        b_w[0] = 8'sd0;
      end
      @(posedge clk);
      #1;
      j = t - (LAT_B - 1);
      if (j >= 0) chk("frac_b", j, b_out[0], tb[j].exp);
    end

    // overflow wraps
    for (int t = 0; t < NC + LAT_C - 1; t++) begin
      if (t < NC) c_in = tc[t].in;
      else c_in = '{default: 0};
      @(posedge clk);
      #1;
      j = t - (LAT_C - 1);
      if (j >= 0) chk("wrap_c", j, c_out[0], tc[j].exp);
    end

    // bias added at the output stage
    a_b = '{1, -1, 2, -2, 3};
    a_in = ta[0].in;
    repeat (LAT_A) @(posedge clk);
    #1;
    chk("bias", 0, a_out[0], -8'sd41);
    chk("bias", 1, a_out[1], 8'sd3);
    chk("bias", 2, a_out[2], 8'sd2);
    chk("bias", 3, a_out[3], -8'sd46);
    chk("bias", 4, a_out[4], -8'sd45);
    a_b = '{default: 0};

    // reset while vectors are in flight
    a_in = ta[0].in;
    @(posedge clk);
    #1;
    a_in = ta[2].in;
    @(posedge clk);
    #1;
    a_in = ta[3].in;
    reset = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) chk("midrst_zero", c, a_out[c], 8'sd0);
    reset = 1'b1;
    a_in = ta[1].in;
    for (int t = 0; t <= LAT_A; t++) begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 5; c++) begin
        if (t <= LAT_A - 2) chk("midrst_flush", t*5 + c, a_out[c], 8'sd0);
        else if (t == LAT_A - 1) chk("midrst_v1", c, a_out[c], ta[1].exp[c]);
        else chk("midrst_v2", c, a_out[c], ta[4].exp[c]);
      end
      if (t == 0) a_in = ta[4].in;
      else a_in = '{default: 0};
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dense_layer.md
# dense_layer

- Fully parallel, pipelined fixed-point dense (fully connected) layer.
- Computes `output_data[c] = bias[c] + Σ_r input_data[r]·weights[r·OUTPUT_SIZE+c]` for every output column in parallel.
- Accepts one new input vector every clock.
- Forms the affine stage of each neural-network layer, upstream of the activation block.

## Interface
Parameters:
- WIDTH, 17, total bits of every signed fixed-point value.
- NFRAC, 10, fractional bits (Q format: WIDTH-NFRAC integer bits incl. sign).
- INPUT_SIZE, 32, input vector length (≥1).
- OUTPUT_SIZE, 1, output vector length (≥1).

Ports:
- clk  in  1  single clock, all registers on rising edge.
- reset  in  1  synchronous, active-low reset.
- input_data  in  signed [WIDTH-1:0] × INPUT_SIZE  input vector.
- weights  in  signed [WIDTH-1:0] × INPUT_SIZE·OUTPUT_SIZE  row-major flattened (INPUT_SIZE, OUTPUT_SIZE) matrix; element (r,c) at index r·OUTPUT_SIZE+c.
- bias  in  signed [WIDTH-1:0] × OUTPUT_SIZE  per-column bias.
- output_data  out  signed [WIDTH-1:0] × OUTPUT_SIZE  registered result.

## Operation
- **Multiply stage.** One product per (r,c): full 2·WIDTH signed product of input_data[r] and weight (r,c). The product is registered.
- **Rescale.** Keep bits [WIDTH+NFRAC-1:NFRAC] of the product.
  - Low bits are truncated, which rounds toward −∞.
  - High bits are discarded, which wraps on overflow. No saturation.
- **Adder tree.** Per column, a binary tree sums the INPUT_SIZE rescaled products.
  - Every level is registered.
  - Pairs are added as WIDTH-bit signed values with wrap-around.
  - An odd leftover element is passed through that level's register unchanged.
  - Depth L = ceil(log2(INPUT_SIZE)); L=0 when INPUT_SIZE=1, in which case the product passes straight through.
- **Bias and output.** Add bias[c] to the tree sum (WIDTH-bit, wraps), then register the result into output_data[c].
- **Sampling of weights and bias.**
  - Weights are sampled together with input_data in the multiply stage.
  - Bias is sampled combinationally at the output stage.
  - Both are expected to be static during operation.
- **Reset.**
  - While reset=0 at a clock edge, every pipeline register and output_data clears to 0.
  - Vectors in flight are lost.
  - The first valid output appears LAT cycles after the first vector presented with reset=1.
- There is no handshake and no valid signal: the pipeline is free-running at full throughput.

## Timing
- LAT = 1 (multiply register) + E + L (tree levels) + 1 (output register).
  - E = 2 when THREE_CYCLE_MULT_EN is defined, otherwise E = 0.
- A vector applied before edge k appears on output_data after edge k+LAT-1.
- Example: INPUT_SIZE=7 gives L=3 and LAT=5 (7 with the macro).
- Throughput: one vector per cycle; consecutive results appear on consecutive cycles.
- Reset value of output_data: all zeros.
- During the first LAT cycles after reset deasserts, output_data reflects partially zero pipeline contents and is not meaningful.

## Configuration
- Macro: THREE_CYCLE_MULT_EN.
- Defined: two extra register stages follow the multiply register, on the rescaled products, so DSP blocks map with full internal pipelining. LAT increases by 2.
- Undefined: rescaled products feed the adder tree directly.
- Arithmetic results are identical in both builds.

## Structure
- Shared package holds:
  - fixed-point typedefs (signed WIDTH word, 2·WIDTH product);
  - the tree-depth function ceil(log2(n));
  - a LAT computation function;
  - the default WIDTH and NFRAC constants.
- One sub-module: adder_tree.
  - Parameterized WIDTH, INPUT_SIZE, OUTPUT_SIZE.
  - Ports: clk, reset, a [INPUT_SIZE][OUTPUT_SIZE] input array and an [OUTPUT_SIZE] output.
  - Built recursively or with generate loops.
  - Latency L, same reset behaviour as the top.
- Multiply, rescale, bias add and output register live in dense_layer.

## Test plan
- **Vector test.** WIDTH=8, NFRAC=0, INPUT_SIZE=7, OUTPUT_SIZE=5, bias 0.
  - input_data = {-1,2,-3,4,-5,6,-7}.
  - weights rows {1,2,3,4,5},{3,4,5,6,7},{5,6,7,8,9},{7,8,9,0,1},{9,0,1,2,3},{1,2,3,4,5},{3,4,5,6,7}.
  - Required: output_data = {-42,4,0,-44,-48}, exactly 5 cycles after application (7 with the macro).
- **Bias.** Same stimulus with bias {1,-1,2,-2,3} -> {-41,3,2,-46,-45}.
- **Fraction and truncation.** WIDTH=8, NFRAC=4, INPUT_SIZE=1, OUTPUT_SIZE=1.
  - 0x18·0x18 -> 0x24 (1.5·1.5=2.25).
  - 0xE8·0x18 -> 0xDC (−2.25).
  - 0xFF·0x01 -> 0xFF (−1/256 floors to −1/16).
  - 0x01·0x01 -> 0x00.
- **Overflow.** WIDTH=8, NFRAC=0, INPUT_SIZE=2: inputs {127,1}, weights {1,1} -> −128 (wrap, no saturation).
- **Throughput.** Apply distinct vectors on 4 consecutive cycles -> 4 correct results on 4 consecutive cycles, in order.
- **Reset mid-stream.** Drive reset=0 for one edge while vectors are in flight.
  - output_data = 0 on the following cycle.
  - Zero-derived values appear until LAT cycles after release.
  - Only vectors applied after release produce correct results.
